bomb_game_ctrl: RTL

- Top-level game sequencer for the bomb-dismantlement game; multi-round successor of the single-round controller.
- Generates a code with an internal LFSR and runs the timed show phase and input phase internally.
- Gates the display, countdown and code-entry modules through enables and a shared module-reset pulse.
- Advances through NUM_ROUNDS rounds, then reports win or loss.

---
 rtl/bomb_game_ctrl.sv | 101 ++++++++++
 1 files changed

// File: rtl/bomb_game_ctrl.sv
// bomb_game_ctrl: multi-round bomb game sequencer (LFSR code, timed show/input phases, win/loss).
// Optional macro BOMB_AUTO_RESTART_EN: WIN/FAIL start a new game after RESTART_SEC ticks.
module bomb_game_ctrl #(
   parameter int                CODE_W      = 5,
   parameter logic [CODE_W-1:0] LFSR_TAPS   = CODE_W'(5'b10100),
   parameter int                NUM_ROUNDS  = 3,
   parameter int                SHOW_SEC    = 5,
   parameter int                INPUT_SEC   = 20,
   parameter int                RESTART_SEC = 3,
   localparam int RND_W   = $clog2(NUM_ROUNDS + 1),
   localparam int MAX_PH  = (SHOW_SEC > INPUT_SEC) ? SHOW_SEC : INPUT_SEC,
   localparam int MAX_SEC = (MAX_PH > RESTART_SEC) ? MAX_PH : RESTART_SEC,
   localparam int SEC_W   = $clog2(MAX_SEC + 1)
) (
   input  logic              clk,
   input  logic              Rst,
   input  logic              enable,
   input  logic              start_btn,
   input  logic              tick,
   input  logic              in_success,
   input  logic              in_fail,
   output logic [CODE_W-1:0] code,
   output logic [RND_W-1:0]  round,
   output logic [SEC_W-1:0]  sec_left,
   output logic              bomb_en,
   output logic              show_en,
   output logic              timer_en,
   output logic              input_en,
   output logic              mod_rst_n,
   output logic              game_won,
   output logic              game_lost
);
   typedef enum logic [2:0] {IDLE, SHOW, INPUT, WIN, FAIL} state_t;
   localparam logic [RND_W-1:0] LAST_RND = RND_W'(NUM_ROUNDS - 1);
   localparam logic [SEC_W-1:0] ONE      = SEC_W'(1);
`ifdef BOMB_AUTO_RESTART_EN
   localparam logic [SEC_W-1:0] END_SEC  = SEC_W'(RESTART_SEC);
`else
   localparam logic [SEC_W-1:0] END_SEC  = '0;
`endif
   state_t state, nxt;
   logic [CODE_W-1:0] lfsr, lfsr_adv;
   logic boot, start_q, en_q, start_rise, expire, new_game, next_round;
   assign lfsr_adv   = lfsr[0] ? (lfsr >> 1) ^ LFSR_TAPS : lfsr >> 1;
   assign start_rise = start_btn & ~start_q;
   // WIN/FAIL hold sec_left at 0 unless auto restart loaded it, so expiry never fires there otherwise
   assign expire     = tick && sec_left == ONE;
   always_comb begin
      nxt = state;
      new_game = 1'b0;
      next_round = 1'b0;
      if (!enable)
         nxt = IDLE;
      else
         case (state)
            IDLE:  new_game = start_rise;
            SHOW:  nxt = expire ? INPUT : SHOW;
            INPUT:
               if (in_fail) nxt = FAIL;
               else if (in_success && round == LAST_RND) nxt = WIN;
               else if (in_success) next_round = 1'b1;
               else if (expire) nxt = FAIL;
            default: new_game = start_rise || expire;
         endcase
      if (new_game || next_round) nxt = SHOW;
   end
   always_ff @(posedge clk) begin
      if (!Rst) begin
         state <= IDLE;
         lfsr <= CODE_W'(1);
         code <= '0;
         round <= '0;
         sec_left <= '0;
         {bomb_en, show_en, timer_en, input_en, game_won, game_lost} <= '0;
         mod_rst_n <= 1'b0;
         boot <= 1'b1;
         start_q <= 1'b0;
         en_q <= 1'b0;
      end else begin
         state <= nxt;
         lfsr <= (lfsr_adv == '0) ? CODE_W'(1) : lfsr_adv;
         start_q <= start_btn;
         en_q <= enable;
         boot <= 1'b0;
         bomb_en <= nxt == SHOW || nxt == INPUT;
         show_en <= nxt == SHOW;
         timer_en <= nxt == INPUT;
         input_en <= nxt == INPUT;
         game_won <= nxt == WIN;
         game_lost <= nxt == FAIL;
         mod_rst_n <= !(boot || (en_q && !enable) || new_game || next_round);
         code <= (nxt == IDLE) ? '0 : (new_game || next_round) ? lfsr : code;
         round <= (nxt == IDLE || new_game) ? '0 : next_round ? round + 1'b1 : round;
         // loads on entry take precedence, so a tick in the entry cycle is not counted
         sec_left <= (nxt == IDLE) ? '0
                   : (new_game || next_round) ? SEC_W'(SHOW_SEC)
                   : (nxt != state) ? ((nxt == INPUT) ? SEC_W'(INPUT_SEC) : END_SEC)
                   : (tick && sec_left != '0) ? sec_left - 1'b1 : sec_left;
      end
   end
endmodule
